// File: rtl/stepmotor_ctrl.sv
// stepmotor_ctrl: four-phase unipolar stepper sequencer driven by a 3-bit DIP.
// dip[2] selects direction (1 = CW, 0 = CCW); dip[1:0] selects the step period
// P = (code + 1) * DIV_BASE clocks. Optional build macro STEPMOTOR_TWO_PHASE_EN
// switches the coil patterns from single-coil to two-coil full step.
module stepmotor_ctrl #(
    parameter int DIV_BASE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] dip,
    output logic [3:0] stepmotor,
    output logic [1:0] state
);

    // Wide enough for every value 0 .. 4*DIV_BASE-1 the prescaler can hold.
    localparam int CNT_W = ($clog2(4 * DIV_BASE) < 1) ? 1 : $clog2(4 * DIV_BASE);
    localparam logic [CNT_W-1:0] BASE = CNT_W'(DIV_BASE);

    // Coil pattern for a given phase index in the active drive mode.
    function automatic logic [3:0] coil_pattern(input logic [1:0] phase);
        logic [3:0] pat;
`ifdef STEPMOTOR_TWO_PHASE_EN
        case (phase)
            2'd0:    pat = 4'b0011;
            2'd1:    pat = 4'b0110;
            2'd2:    pat = 4'b1100;
            default: pat = 4'b1001;
        endcase
`else
        case (phase)
            2'd0:    pat = 4'b0001;
            2'd1:    pat = 4'b0010;
            2'd2:    pat = 4'b0100;
            default: pat = 4'b1000;
        endcase
`endif
        return pat;
    endfunction

    logic [2:0]       dip_meta_q;
    logic [2:0]       dip_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       coil_q, coil_d;
    logic [CNT_W-1:0] period_m1;
    logic             step_tick;

    // P-1 computed modulo 2^CNT_W: the product can wrap to zero at 4*DIV_BASE
    // when that is a power of two, and subtracting one still lands on P-1.
    assign period_m1 = (CNT_W'(dip_s_q[1:0]) + CNT_W'(1)) * BASE - CNT_W'(1);

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dip_meta_q <= 3'b000;
            dip_s_q    <= 3'b000;
        end else begin
            dip_meta_q <= dip;
            dip_s_q    <= dip_meta_q;
        end
    end

    // Next-state: prescaler wraps on >= so a shorter period never stalls,
    // and each wrap advances the phase in the synchronized direction.
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = state_q;
        coil_d    = coil_q;
        step_tick = (cnt_q >= period_m1);
        if (step_tick) begin
            cnt_d   = '0;
            state_d = dip_s_q[2] ? (state_q + 2'd1) : (state_q - 2'd1);
            coil_d  = coil_pattern(state_d);
        end
    end

    // State registers; reset wins over a coincident step tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= 2'd0;
            coil_q  <= coil_pattern(2'd0);
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            coil_q  <= coil_d;
        end
    end

    assign stepmotor = coil_q;
    assign state     = state_q;

endmodule

// File: tb/tb_stepmotor_ctrl.sv
// Bench for stepmotor_ctrl: directed DIP/reset sequence, a behavioural model
// compared every cycle, and hand-computed literal points along the run.
module tb_stepmotor_ctrl;

    localparam int DIV_BASE = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dip;
    logic [3:0] stepmotor;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    stepmotor_ctrl #(.DIV_BASE(DIV_BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .dip       (dip),
        .stepmotor (stepmotor),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Literal coil table for the active mode, indexed by phase.
    logic [3:0] lit_pat [4];
    initial begin
`ifdef STEPMOTOR_TWO_PHASE_EN
        lit_pat[0] = 4'b0011; lit_pat[1] = 4'b0110;
        lit_pat[2] = 4'b1100; lit_pat[3] = 4'b1001;
`else
        lit_pat[0] = 4'b0001; lit_pat[1] = 4'b0010;
        lit_pat[2] = 4'b0100; lit_pat[3] = 4'b1000;
`endif
    end

    // ---------------- behavioural model ----------------
    // The switch value seen by the sequencer lags the pins by two edges; a step
    // happens once P clocks have elapsed since the previous step (or reset).
    logic [2:0] m_s1, m_s2;
    int         m_since;
    int         m_phase;
    int         m_period;
    bit         m_valid = 1'b0;

    function automatic logic [3:0] model_pat(input int ph);
        logic [7:0] w;
`ifdef STEPMOTOR_TWO_PHASE_EN
        w = {4'b0011, 4'b0011} << ph;   // rotate 0011 left by ph
        return w[7:4] | w[3:0] & 4'b0000 | (w[7:4] == 4'b0000 ? w[3:0] : 4'b0000);
`else
        w = 8'b0000_0001 << ph;
        return w[3:0];
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_s1    = 3'b000;
            m_s2    = 3'b000;
            m_since = 0;
            m_phase = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_period = (int'(m_s2[1:0]) + 1) * DIV_BASE;
            m_since  = m_since + 1;
            if (m_since >= m_period) begin
                m_since = 0;
                m_phase = m_s2[2] ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
            end
            m_s2 = m_s1;
            m_s1 = dip;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (state !== m_phase[1:0] || stepmotor !== model_pat(m_phase)) begin
                errors++;
                $display("FAIL model t=%0t: state=%b stepmotor=%b, required state=%b stepmotor=%b",
                         $time, state, stepmotor, m_phase[1:0], model_pat(m_phase));
            end
        end
    end

    // ---------------- literal checks ----------------
    task automatic lit(input string name, input logic [1:0] exp_state);
        checks++;
        if (state !== exp_state || stepmotor !== lit_pat[exp_state]) begin
            errors++;
            $display("FAIL %s: state=%b stepmotor=%b, required state=%b stepmotor=%b",
                     name, state, stepmotor, exp_state, lit_pat[exp_state]);
        end else begin
            $display("check %s: state=%b stepmotor=%b", name, state, stepmotor);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct { logic [2:0] d; int n; } seg_t;
    seg_t segs [6];

    initial begin
        rst = 1'b1;
        dip = 3'b000;
        cycles(1);                          // edge 0 under reset
        lit("reset", 2'd0);

        // CCW, code 2: two edges at P=1 before the new code arrives, then P=3.
        rst = 1'b0;
        dip = 3'b010;
        cycles(1); lit("ccw_e1", 2'd3);
        cycles(1); lit("ccw_e2", 2'd2);
        cycles(2); lit("ccw_e4_hold", 2'd2);
        cycles(1); lit("ccw_e5", 2'd1);

        // Reverse to CW, code 1: takes effect two edges later with P=2.
        dip = 3'b101;
        cycles(2); lit("rev_e7_hold", 2'd1);
        cycles(1); lit("rev_e8_cw", 2'd2);
        cycles(2); lit("rev_e10", 2'd3);

        // Slowest speed with wrap 3 -> 0.
        dip = 3'b111;
        cycles(2); lit("wrap_e12", 2'd0);
        cycles(3); lit("slow_e15_hold", 2'd0);
        cycles(1); lit("slow_e16", 2'd1);
        cycles(12); lit("slow_e28_wrap", 2'd0);

        // Reset while counter is at P-1: no step, fresh period afterwards.
        cycles(3);                          // counter now 3 = P-1
        rst = 1'b1;
        cycles(1); lit("midrst_e32", 2'd0);
        rst = 1'b0;
        cycles(1); lit("midrst_e33_ccw_p1", 2'd3);

        // Held multi-cycle reset.
        cycles(5);
        rst = 1'b1;
        cycles(3); lit("long_rst", 2'd0);
        rst = 1'b0;

        // Mixed speeds/directions, including a slow-to-fast change.
        segs[0] = '{3'b011, 9};
        segs[1] = '{3'b000, 5};
        segs[2] = '{3'b110, 7};
        segs[3] = '{3'b001, 6};
        segs[4] = '{3'b100, 10};
        segs[5] = '{3'b111, 11};
        foreach (segs[i]) begin
            dip = segs[i].d;
            cycles(segs[i].n);
        end

        cycles(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
